// File: rtl/decode_ctrl.sv
// Decode/control stage ahead of the ALU: latches the fetched instruction, decodes its fields and
// sequences FETCH->DECODE->REGREAD->ALU->(MEM)->WB. Optional macro DECODE_ILLEGAL_TRAP_EN traps opcodes 6/7.
module decode_ctrl #(
  parameter logic [1:0]  RESET_PC_OP = 2'b11,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [15:0] I_instr,
  input  logic        I_memReady,
  input  logic        I_shldBranch,
  output logic [5:0]  O_state,
  output logic [4:0]  O_aluop,
  output logic [2:0]  O_selD,
  output logic [2:0]  O_selA,
  output logic [2:0]  O_selB,
  output logic [7:0]  O_imm,
  output logic        O_aluEn,
  output logic        O_regWe,
  output logic        O_memReq,
  output logic        O_memWe,
  output logic [1:0]  O_pcop,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic        O_illegal,
`endif
  output logic        O_timeout
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [5:0] {
    ST_HALT    = 6'b000000,
    ST_FETCH   = 6'b000001,
    ST_DECODE  = 6'b000010,
    ST_REGREAD = 6'b000100,
    ST_ALU     = 6'b001000,
    ST_MEM     = 6'b010000,
    ST_WB      = 6'b100000
  } state_t;

  state_t             r_state;
  logic               r_rst_hold;
  logic [CNT_W-1:0]   r_wait;

  logic [3:0] w_opcode;
  logic       w_writes_d;
  logic       w_branch;
  logic       w_load;
  logic       w_store;
  logic       w_resv;
  logic       w_wait_done;
  logic [1:0] w_wb_pcop;

  assign O_state     = r_state;
  assign w_opcode    = O_aluop[4:1];
  assign w_wait_done = (MEM_TIMEOUT != 0) && (r_wait == CNT_W'(MEM_TIMEOUT - 1));
  assign w_wb_pcop   = (w_branch && I_shldBranch) ? 2'b10 : 2'b01;

  // Instruction class from the latched opcode
  always_comb begin
    w_writes_d = 1'b0;
    w_branch   = 1'b0;
    w_load     = 1'b0;
    w_store    = 1'b0;
    w_resv     = 1'b0;
    case (w_opcode)
      4'd6, 4'd7:   w_resv   = 1'b1;
      4'd12, 4'd13: w_branch = 1'b1;
      4'd14:        w_load   = 1'b1;
      4'd15:        w_store  = 1'b1;
      default:      w_writes_d = 1'b1;
    endcase
  end

  // Sequencer; every output is set on the edge that enters the state it belongs to
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state    <= ST_FETCH;
      r_rst_hold <= 1'b1;
      r_wait     <= '0;
      O_aluop    <= '0;
      O_selD     <= '0;
      O_selA     <= '0;
      O_selB     <= '0;
      O_imm      <= '0;
      O_aluEn    <= 1'b0;
      O_regWe    <= 1'b0;
      O_memReq   <= 1'b0;
      O_memWe    <= 1'b0;
      O_pcop     <= RESET_PC_OP;
      O_timeout  <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      O_illegal  <= 1'b0;
`endif
    end else begin
      O_aluEn <= 1'b0;
      O_regWe <= 1'b0;
      O_pcop  <= 2'b00;
      if (r_rst_hold) begin
        // Release cycle: PC stays in reset, memory request starts for the first fetch
        r_rst_hold <= 1'b0;
        O_pcop     <= RESET_PC_OP;
        O_memReq   <= 1'b1;
      end else begin
        case (r_state)
          ST_FETCH: begin
            if (I_memReady) begin
              O_aluop  <= {I_instr[15:12], I_instr[8]};
              O_selD   <= I_instr[11:9];
              O_selA   <= I_instr[7:5];
              O_selB   <= I_instr[4:2];
              O_imm    <= I_instr[7:0];
              O_memReq <= 1'b0;
              r_wait   <= '0;
              r_state  <= ST_DECODE;
            end else if (w_wait_done) begin
              O_timeout <= 1'b1;
              r_wait    <= '0;
            end else begin
              r_wait <= r_wait + CNT_W'(1);
            end
          end
          ST_DECODE: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (w_resv) begin
              O_illegal <= 1'b1;
              r_state   <= ST_HALT;
            end else begin
              r_state <= ST_REGREAD;
            end
`else
            r_state <= ST_REGREAD;
`endif
          end
          ST_REGREAD: begin
            O_aluEn <= 1'b1;
            r_state <= ST_ALU;
          end
          ST_ALU: begin
            if (w_load || w_store) begin
              O_memReq <= 1'b1;
              O_memWe  <= w_store;
              r_wait   <= '0;
              r_state  <= ST_MEM;
            end else begin
              O_regWe <= w_writes_d;
              O_pcop  <= w_wb_pcop;
              r_state <= ST_WB;
            end
          end
          ST_MEM: begin
            if (I_memReady || w_wait_done) begin
              // A timed-out load must not write the register file
              O_regWe   <= w_writes_d || (w_load && I_memReady);
              O_pcop    <= w_wb_pcop;
              O_timeout <= O_timeout || !I_memReady;
              O_memReq  <= 1'b0;
              O_memWe   <= 1'b0;
              r_wait    <= '0;
              r_state   <= ST_WB;
            end else begin
              r_wait <= r_wait + CNT_W'(1);
            end
          end
          ST_WB: begin
            O_memReq <= 1'b1;
            r_state  <= ST_FETCH;
          end
          ST_HALT: begin
            O_memReq <= 1'b0;
            O_memWe  <= 1'b0;
          end
          default: begin
            O_memReq <= 1'b1;
            O_memWe  <= 1'b0;
            r_state  <= ST_FETCH;
          end
        endcase
      end
    end
  end

  logic w_unused;
  assign w_unused = w_resv;

endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl: the driver queues expected WB results, a negedge monitor checks them.
module tb_decode_ctrl;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b0;
  logic [15:0] I_instr = 16'h0;
  logic        I_memReady = 1'b0;
  logic        I_shldBranch = 1'b0;
  logic [5:0]  O_state;
  logic [4:0]  O_aluop;
  logic [2:0]  O_selD, O_selA, O_selB;
  logic [7:0]  O_imm;
  logic        O_aluEn, O_regWe, O_memReq, O_memWe, O_timeout;
  logic [1:0]  O_pcop;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        O_illegal;
`endif

  decode_ctrl dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_instr(I_instr), .I_memReady(I_memReady),
    .I_shldBranch(I_shldBranch), .O_state(O_state), .O_aluop(O_aluop),
    .O_selD(O_selD), .O_selA(O_selA), .O_selB(O_selB), .O_imm(O_imm),
    .O_aluEn(O_aluEn), .O_regWe(O_regWe), .O_memReq(O_memReq), .O_memWe(O_memWe),
    .O_pcop(O_pcop),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .O_illegal(O_illegal),
`endif
    .O_timeout(O_timeout)
  );

  always #5 I_clk = ~I_clk;

  localparam logic [5:0] S_FETCH = 6'h01, S_DEC = 6'h02, S_RR = 6'h04,
                         S_ALU = 6'h08, S_MEM = 6'h10, S_WB = 6'h20;

  typedef struct {
    logic [15:0] instr;
    logic        shld;
    int          mem;     // MEM cycles, 0 for non-memory instructions
    logic        mem_to;  // never answer in MEM
    logic        regwe;
    logic [1:0]  pcop;
    logic [4:0]  aluop;
    logic [2:0]  d, a, b;
    logic [7:0]  imm;
    logic        memwe;
  } vec_t;

  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: per-cycle invariants plus scoreboard check at every WB
  int   n_cyc = 0;
  int   n_mem = 0;
  logic we_seen = 1'b0;
  always @(negedge I_clk) begin
    if (!I_rst) begin
      if (O_state == S_DEC) begin
        n_cyc = 1; n_mem = 0; we_seen = 1'b0;
      end else if (O_state inside {S_RR, S_ALU, S_MEM, S_WB}) begin
        n_cyc++;
      end
      if (O_state == S_MEM) begin
        n_mem++;
        we_seen |= O_memWe;
        chk("mem_req_in_mem", 32'(O_memReq), 32'd1);
      end
      chk("alu_en_only_alu", 32'(O_aluEn), 32'(O_state == S_ALU));
      if (O_state inside {S_DEC, S_RR, S_ALU, S_MEM})
        chk("pcop_idle", 32'(O_pcop), 32'd0);
      if (O_state != S_WB) begin
        chk("regwe_outside_wb", 32'(O_regWe), 32'd0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_wb", 32'd1, 32'd0);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk("wb_regwe", 32'(O_regWe), 32'(e.regwe));
        chk("wb_pcop",  32'(O_pcop),  32'(e.pcop));
        chk("aluop",    32'(O_aluop), 32'(e.aluop));
        chk("selD",     32'(O_selD),  32'(e.d));
        chk("selA",     32'(O_selA),  32'(e.a));
        chk("selB",     32'(O_selB),  32'(e.b));
        chk("imm",      32'(O_imm),   32'(e.imm));
        chk("mem_cycles", 32'(n_mem), 32'(e.mem));
        chk("mem_we",   32'(we_seen), 32'(e.memwe));
        chk("latency",  32'(n_cyc),   32'(4 + e.mem));
      end
    end
  end

  function automatic vec_t mk(logic [15:0] instr, logic shld, int mem, logic mem_to,
                              logic regwe, logic [1:0] pcop, logic [4:0] aluop,
                              logic [2:0] d, logic [2:0] a, logic [2:0] b,
                              logic [7:0] imm, logic memwe);
    vec_t v;
    v.instr = instr; v.shld = shld; v.mem = mem; v.mem_to = mem_to;
    v.regwe = regwe; v.pcop = pcop; v.aluop = aluop;
    v.d = d; v.a = a; v.b = b; v.imm = imm; v.memwe = memwe;
    return v;
  endfunction

  // Enter reset, check reset values, release and check the held reset pcop
  task automatic do_reset();
    @(negedge I_clk);
    I_rst = 1'b1; I_memReady = 1'b0;
    @(negedge I_clk);
    chk("rst_state",   32'(O_state),   32'(S_FETCH));
    chk("rst_pcop",    32'(O_pcop),    32'd3);
    chk("rst_memreq",  32'(O_memReq),  32'd0);
    chk("rst_regwe",   32'(O_regWe),   32'd0);
    chk("rst_timeout", 32'(O_timeout), 32'd0);
    chk("rst_aluop",   32'(O_aluop),   32'd0);
    I_rst = 1'b0;
    @(posedge I_clk); #1;
    chk("rel_pcop",   32'(O_pcop),   32'd3);
    chk("rel_memreq", 32'(O_memReq), 32'd1);
    @(posedge I_clk); #1;
    chk("post_rel_pcop",  32'(O_pcop),  32'd0);
    chk("post_rel_state", 32'(O_state), 32'(S_FETCH));
  endtask

  // Issue one instruction from FETCH; returns at the WB negedge
  task automatic run(input vec_t v);
    exp_q.push_back(v);
    @(negedge I_clk);
    I_instr = v.instr; I_shldBranch = v.shld; I_memReady = 1'b1;
    @(posedge I_clk);
    @(negedge I_clk);
    I_instr = 16'hFFFF;
    I_memReady = (v.mem == 0);  // ready outside FETCH/MEM must be ignored
    repeat (2) @(negedge I_clk);
    for (int j = 1; j <= v.mem; j++) begin
      @(negedge I_clk);
      if (j == v.mem && !v.mem_to) I_memReady = 1'b1;
    end
    @(negedge I_clk);
    I_memReady = 1'b0;
  endtask

  initial begin
    do_reset();
    run(mk(16'h0244, 1'b0, 0, 1'b0, 1'b1, 2'b01, 5'h00, 3'd1, 3'd2, 3'd1, 8'h44, 1'b0));
    run(mk(16'hC000, 1'b1, 0, 1'b0, 1'b0, 2'b10, 5'h18, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0));
    run(mk(16'hD000, 1'b0, 0, 1'b0, 1'b0, 2'b01, 5'h1A, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0));
    run(mk(16'hD100, 1'b1, 0, 1'b0, 1'b0, 2'b10, 5'h1B, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0));
    run(mk(16'hE000, 1'b0, 3, 1'b0, 1'b1, 2'b01, 5'h1C, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0));
    run(mk(16'hF000, 1'b0, 1, 1'b0, 1'b0, 2'b01, 5'h1E, 3'd0, 3'd0, 3'd0, 8'h00, 1'b1));
    run(mk(16'h8A5F, 1'b1, 0, 1'b0, 1'b1, 2'b01, 5'h10, 3'd5, 3'd2, 3'd7, 8'h5F, 1'b0));
    run(mk(16'hBFFF, 1'b1, 0, 1'b0, 1'b1, 2'b01, 5'h17, 3'd7, 3'd7, 3'd7, 8'hFF, 1'b0));
`ifndef DECODE_ILLEGAL_TRAP_EN
    run(mk(16'h6000, 1'b1, 0, 1'b0, 1'b0, 2'b01, 5'h0C, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0));
    run(mk(16'h7B00, 1'b0, 0, 1'b0, 1'b0, 2'b01, 5'h0F, 3'd5, 3'd0, 3'd0, 8'h00, 1'b0));
`endif

    // Reset in ALU aborts the instruction (nothing queued, so any WB is flagged)
    @(negedge I_clk);
    I_instr = 16'h0244; I_memReady = 1'b1;
    @(posedge I_clk);
    @(negedge I_clk);
    I_memReady = 1'b0;
    repeat (2) @(negedge I_clk);
    chk("abort_in_alu", 32'(O_state), 32'(S_ALU));
    I_rst = 1'b1;
    #1;
    chk("abort_state", 32'(O_state), 32'(S_FETCH));
    chk("abort_aluen", 32'(O_aluEn), 32'd0);
    chk("abort_pcop",  32'(O_pcop),  32'd3);
    chk("abort_selD",  32'(O_selD),  32'd0);
    @(negedge I_clk);
    I_rst = 1'b0;
    @(posedge I_clk); #1;
    chk("abort_rel_pcop", 32'(O_pcop), 32'd3);
    @(posedge I_clk); #1;
    chk("abort_post_pcop",  32'(O_pcop),  32'd0);
    chk("abort_post_regwe", 32'(O_regWe), 32'd0);

    // FETCH timeout: the 15th waiting cycle raises the sticky flag
    do_reset();
    repeat (13) @(posedge I_clk);
    #1 chk("fetch_to_early", 32'(O_timeout), 32'd0);
    @(posedge I_clk);
    #1 chk("fetch_to_set", 32'(O_timeout), 32'd1);
    chk("fetch_to_state", 32'(O_state), 32'(S_FETCH));
    run(mk(16'h0244, 1'b0, 0, 1'b0, 1'b1, 2'b01, 5'h00, 3'd1, 3'd2, 3'd1, 8'h44, 1'b0));
    chk("fetch_to_sticky", 32'(O_timeout), 32'd1);

    // MEM timeout on a load: 15 MEM cycles, then WB without a write
    do_reset();
    run(mk(16'hE000, 1'b0, 15, 1'b1, 1'b0, 2'b01, 5'h1C, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0));
    chk("mem_to_set", 32'(O_timeout), 32'd1);

`ifdef DECODE_ILLEGAL_TRAP_EN
    do_reset();
    @(negedge I_clk);
    I_instr = 16'h6000; I_memReady = 1'b1;
    @(posedge I_clk);
    @(negedge I_clk);
    I_memReady = 1'b0;
    chk("ill_decode", 32'(O_state), 32'(S_DEC));
    @(negedge I_clk);
    chk("ill_state", 32'(O_state), 32'd0);
    chk("ill_flag",  32'(O_illegal), 32'd1);
    I_memReady = 1'b1;
    repeat (4) @(negedge I_clk);
    chk("ill_hold_state", 32'(O_state), 32'd0);
    chk("ill_hold_req",   32'(O_memReq), 32'd0);
    chk("ill_hold_pcop",  32'(O_pcop), 32'd0);
    chk("ill_hold_flag",  32'(O_illegal), 32'd1);
    do_reset();
    chk("ill_cleared", 32'(O_illegal), 32'd0);
`endif

    repeat (3) @(negedge I_clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/decode_ctrl.md
Name: decode_ctrl

Overview:
- Upstream stage of the ALU: latches the fetched 16-bit instruction, decodes it into ALU opcode, register selects and immediate, and sequences the multi-cycle FETCH→DECODE→REGREAD→ALU→MEM→WB flow.
- Drives ALU enable, register-file write enable and program-counter ops.
- Samples the ALU branch flag to choose PC assign vs. PC increment.
- Posedge logic; the ALU executes on the intervening negedge.

Parameters:
- RESET_PC_OP, 2'b11, value of O_pcop held during reset and for the first cycle after it.
- MEM_TIMEOUT, 15, maximum cycles to wait in FETCH/MEM for I_memReady before raising O_timeout; 0 disables the timeout.

Ports:
- I_clk  input  1  system clock, posedge
- I_rst  input  1  asynchronous, active-high reset
- I_instr  input  16  instruction word from instruction memory, valid when I_memReady=1 in FETCH
- I_memReady  input  1  memory handshake: fetch or data access complete this cycle
- I_shldBranch  input  1  ALU branch decision
- O_state  output  6  one-hot state {WB,MEM,ALU,REGREAD,DECODE,FETCH}
- O_aluop  output  5  {instr[15:12], instr[8]}
- O_selD  output  3  instr[11:9]
- O_selA  output  3  instr[7:5]
- O_selB  output  3  instr[4:2]
- O_imm  output  8  instr[7:0]
- O_aluEn  output  1  high only in ALU state
- O_regWe  output  1  register-file write strobe
- O_memReq  output  1  request to memory
- O_memWe  output  1  data-memory write, valid with O_memReq in MEM
- O_pcop  output  2  00 hold, 01 increment, 10 assign (branch), 11 reset
- O_timeout  output  1  sticky: memory handshake timed out

Behaviour:
- Reset (async, I_rst=1):
  - state=FETCH, all decode outputs 0, O_aluEn/O_regWe/O_memReq/O_memWe/O_timeout=0, O_pcop=RESET_PC_OP.
  - First posedge after deassertion keeps O_pcop=RESET_PC_OP; normal operation follows.
- Reset mid-instruction aborts it: no O_regWe or pcop side effects are emitted afterwards.
- FETCH:
  - O_memReq=1.
  - Stay until I_memReady=1, then latch I_instr and go to DECODE.
  - Each cycle waiting increments the wait counter.
  - If the counter reaches MEM_TIMEOUT (≠0): set O_timeout and restart FETCH with counter=0.
- DECODE:
  - Decode fields become registered from the latched word; all field outputs valid from this state until the next FETCH latch.
  - Classify: writesD = opcode in {0,1,2,3,4,5,8,9,10,11}; branch = opcode in {12,13}; memLoad = opcode 14; memStore = opcode 15; opcodes 6,7 = reserved.
  - Next state: REGREAD.
- REGREAD: one cycle; register file reads selA/selB. Next: ALU.
- ALU:
  - O_aluEn=1 for exactly this cycle; the ALU result and O_shldBranch are valid at the next posedge.
  - Next: MEM if memLoad or memStore, else WB.
- MEM:
  - O_memReq=1; O_memWe=memStore.
  - Wait for I_memReady with the same timeout rule as FETCH; on timeout set O_timeout and go to WB without writing.
- WB (one cycle):
  - O_regWe=1 iff writesD or (memLoad and no timeout).
  - O_pcop=10 if branch and I_shldBranch=1, else 01.
  - Next: FETCH.
- Outside WB and reset, O_pcop=00.
- O_regWe and O_pcop≠00 are single-cycle pulses.
- Latency: minimum 5 cycles per non-memory instruction, with FETCH ready in its first cycle.
- I_memReady outside FETCH/MEM is ignored.
- O_timeout clears only on reset.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Enabled:
  - Reserved opcodes 6/7 in DECODE go to a HALT state, with O_state=6'b000000.
  - Adds output O_illegal (1 bit), set sticky in HALT.
  - In HALT: no requests, O_pcop=00; exit only via reset.
- Disabled: reserved opcodes execute as NOP through all states with O_regWe=0 and O_pcop=01 in WB.

Test Plan:
- Reset then I_instr=16'h0244 (add r1,r2,r1) with I_memReady=1 → O_state walks 000001→000010→000100→001000→100000; O_aluop=00000, selD=1, selA=2, selB=1; WB O_regWe=1, O_pcop=01.
- Instr 16'hC000 (JMPA imm) with I_shldBranch=1 at WB → O_pcop=10, O_regWe=0; with opcode 13 and I_shldBranch=0 → O_pcop=01.
- Instr 16'hE000 (memLoad) with I_memReady delayed 3 cycles in MEM → MEM held 3 cycles with O_memReq=1, O_memWe=0, then WB O_regWe=1; opcode 15 → O_memWe=1 in MEM, O_regWe=0.
- I_memReady held 0 for 15 FETCH cycles → O_timeout=1, FETCH restarts and completes normally when ready returns.
- Assert I_rst during ALU state → outputs clear immediately; O_pcop=11 for reset plus one cycle; no O_regWe pulse.
- Opcode 6: with DECODE_ILLEGAL_TRAP_EN → O_illegal=1, O_state=0, held until reset; without it → O_regWe=0, O_pcop=01.
